muldiv_seq: RTL and testbench

//   Multi-cycle sequencer for the HI/LO arithmetic unit behind the EXE stage.

---
 rtl/muldiv_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// MulDivSeq: multi-cycle sequencer for the HI/LO arithmetic unit.
//
// MULT/MULTU run as shift-add and DIV/DIVU as restoring division, one bit per
// clock. The operands are converted to magnitudes when the operation starts,
// and the sign is corrected in a single FIX cycle at the end. busy lets the
// execute stage stall. done pulses for one cycle when {hi,lo} becomes valid.
//
// Ports:
//   clk     in   1       clock, rising edge
//   resetn  in   1       asynchronous, active-low reset
//   start   in   1       issue request, sampled only in IDLE or DONE
//   op      in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1    in   DATA_W  multiplicand / dividend
//   src2    in   DATA_W  multiplier / divisor
//   cancel  in   1       flush, aborts any operation in flight
//   busy    out  1       high while CALC or FIX
//   done    out  1       one-cycle pulse, hi/lo valid from this cycle on
//   hi      out  DATA_W  product upper half / remainder
//   lo      out  DATA_W  product lower half / quotient
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    isDiv_q, isDiv_d;
    logic                    negRes_q, negRes_d;
    logic                    negRem_q, negRem_d;
    logic                    divZero_q, divZero_d;
    logic [DATA_W-1:0]       opb_q, opb_d;
    logic [2*DATA_W-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0]       hi_q, hi_d;
    logic [DATA_W-1:0]       lo_q, lo_d;

    logic                    acceptStart;
    logic                    lastIter;
    logic                    isSignedOp;
    logic                    src1Neg;
    logic                    src2Neg;
    logic [DATA_W-1:0]       src1Mag;
    logic [DATA_W-1:0]       src2Mag;

    logic [DATA_W:0]         mulSum;
    logic [2*DATA_W-1:0]     mulNext;
    logic [DATA_W:0]         divShifted;
    logic                    divFits;
    logic [DATA_W-1:0]       divRem;
    logic [2*DATA_W-1:0]     divNext;

    logic [2*DATA_W-1:0]     prodFix;
    logic [DATA_W-1:0]       quotFix;
    logic [DATA_W-1:0]       remFix;

    // Issue decode: a start is only taken when no operation is in flight,
    // and cancel in the same cycle always wins over it.
    always_comb begin
        acceptStart = start & ~cancel & ((state_q == IDLE) | (state_q == DONE));
        lastIter    = (cnt_q == CNT_W'(DATA_W - 1));
        isSignedOp  = ~op[0];
        src1Neg     = isSignedOp & src1[DATA_W-1];
        src2Neg     = isSignedOp & src2[DATA_W-1];
        src1Mag     = src1Neg ? -src1 : src1;
        src2Mag     = src2Neg ? -src2 : src2;
    end

    // One iteration of each algorithm on the shared accumulator.
    // Multiply keeps {partial product, remaining multiplier} and shifts right.
    // Divide keeps {partial remainder, remaining dividend / quotient bits}
    // and shifts left; the remainder always stays below the divisor, so the
    // subtraction only needs the low DATA_W bits.
    always_comb begin
        mulSum     = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opb_q};
        mulNext    = acc_q[0] ? {mulSum, acc_q[DATA_W-1:1]}
                              : {1'b0, acc_q[2*DATA_W-1:1]};
        divShifted = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        divFits    = (divShifted >= {1'b0, opb_q});
        divRem     = divFits ? (divShifted[DATA_W-1:0] - opb_q)
                             : divShifted[DATA_W-1:0];
        divNext    = {divRem, acc_q[DATA_W-2:0], divFits};
    end

    // Sign correction of the magnitude results. A zero divisor forces the
    // quotient to all ones; the remainder then already equals the raw
    // dividend because it carries the dividend's sign.
    always_comb begin
        prodFix = negRes_q ? -acc_q : acc_q;
        remFix  = negRem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        if (divZero_q) begin
            quotFix = '1;
        end else if (negRes_q) begin
            quotFix = -acc_q[DATA_W-1:0];
        end else begin
            quotFix = acc_q[DATA_W-1:0];
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acceptStart) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (lastIter) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = acceptStart ? CALC : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (cancel) begin
            state_d = IDLE;
        end
    end

    // Datapath next values: operand latch on accepted start, one iteration
    // per CALC cycle, and the result registers loaded only from FIX.
    always_comb begin
        cnt_d     = cnt_q;
        isDiv_d   = isDiv_q;
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
        divZero_d = divZero_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (acceptStart) begin
            cnt_d     = '0;
            isDiv_d   = op[1];
            negRes_d  = src1Neg ^ src2Neg;
            negRem_d  = src1Neg;
            divZero_d = op[1] & (src2 == '0);
            if (op[1]) begin
                acc_d = {{DATA_W{1'b0}}, src1Mag};
                opb_d = src2Mag;
            end else begin
                acc_d = {{DATA_W{1'b0}}, src2Mag};
                opb_d = src1Mag;
            end
        end else if (state_q == CALC) begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = isDiv_q ? divNext : mulNext;
        end else if ((state_q == FIX) && !cancel) begin
            if (isDiv_q) begin
                hi_d = remFix;
                lo_d = quotFix;
            end else begin
                hi_d = prodFix[2*DATA_W-1:DATA_W];
                lo_d = prodFix[DATA_W-1:0];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            opb_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isDiv_q   <= isDiv_d;
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
            divZero_q <= divZero_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// Self-checking bench for muldiv_seq: vector table plus directed sequences
// for cancel, back-to-back issue, busy-time start pulses and mid-op reset.
// Expected {hi,lo} pairs go into a scoreboard queue when an operation is
// issued and are popped by a monitor whenever done is seen.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

    localparam int W = 32;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  src1;
    logic [W-1:0]  src2;
    logic          cancel;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expHi;
        logic [W-1:0] expLo;
        string        name;
    } vec_t;

    typedef struct {
        logic [W-1:0] expHi;
        logic [W-1:0] expLo;
        string        name;
    } sb_t;

    sb_t           scoreboard[$];
    vec_t          vecs[12];
    int            checks;
    int            errors;
    int            latCount;
    int            doneSeen;
    logic [W-1:0]  lastHi;
    logic [W-1:0]  lastLo;

    muldiv_seq #(.DATA_W(W), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done must match the oldest issued operation.
    always @(negedge clk) begin
        if (resetn && done) begin
            if (scoreboard.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                sb_t e;
                e = scoreboard.pop_front();
                checkOutput({e.name, "_hi"}, hi, e.expHi);
                checkOutput({e.name, "_lo"}, lo, e.expLo);
            end
        end
    end

    // Reference model built from native operators on 64-bit values.
    function automatic logic [2*W-1:0] model(input logic [1:0] mop, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa;
        longint       sb;
        logic [2*W-1:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (mop)
            2'b00:   r = 64'(sa * sb);
            2'b01:   r = {32'b0, a} * {32'b0, b};
            2'b10:   r = {32'(sa % sb), 32'(sa / sb)};
            default: r = {a % b, a / b};
        endcase
        return r;
    endfunction

    // Drives start for one cycle from a negedge; returns at the negedge of
    // cycle 1 with latCount = 1.
    task automatic applyStimulus(input logic [1:0] vop, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] expHi, input logic [W-1:0] expLo,
                                 input bit doPush, input string name);
        sb_t e;
        start = 1'b1;
        op    = vop;
        src1  = a;
        src2  = b;
        if (doPush) begin
            e.expHi = expHi;
            e.expLo = expLo;
            e.name  = name;
            scoreboard.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        latCount = 1;
        checkOutput({name, "_busy_c1"}, W'(busy), W'(1));
    endtask

    task automatic waitDone(input int expLat, input string name);
        while (!done && latCount < 200) begin
            @(negedge clk);
            latCount++;
        end
        checkOutput({name, "_latency"}, W'(latCount), W'(expLat));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        latCount = 0;
        doneSeen = 0;
        resetn   = 1'b0;
        start    = 1'b0;
        cancel   = 1'b0;
        op       = 2'b00;
        src1     = '0;
        src2     = '0;

        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7"};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
        vecs[3]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, "divu_by0"};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
        vecs[5]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,        "divu_100d7"};
        vecs[6]  = '{2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, "mult_maxxm1"};
        vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin"};
        vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2"};
        vecs[9]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, "div_m7dm2"};
        vecs[10] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_neg_by0"};
        vecs[11] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "multu_carry"};

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", W'(busy), W'(0));
        checkOutput("reset_done", W'(done), W'(0));
        checkOutput("reset_hi", hi, W'(0));
        checkOutput("reset_lo", lo, W'(0));
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, 1'b1, vecs[i].name);
            waitDone(34, vecs[i].name);
            @(negedge clk);
            checkOutput({vecs[i].name, "_done_pulse"}, W'(done), W'(0));
            checkOutput({vecs[i].name, "_hold_lo"}, lo, vecs[i].expLo);
        end

        for (int i = 0; i < 6; i++) begin
            logic [1:0]     rop;
            logic [W-1:0]   ra;
            logic [W-1:0]   rb;
            logic [2*W-1:0] r;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (rb == '0) rb = 32'd1;
            r = model(rop, ra, rb);
            applyStimulus(rop, ra, rb, r[2*W-1:W], r[W-1:0], 1'b1, "random");
            waitDone(34, "random");
            lastHi = r[2*W-1:W];
            lastLo = r[W-1:0];
            @(negedge clk);
        end

        // Cancel in cycle 10 of a DIVU: no done, hi/lo keep prior values.
        applyStimulus(2'b11, 32'd100, 32'd7, '0, '0, 1'b0, "cancel_divu");
        while (latCount < 10) begin
            @(negedge clk);
            latCount++;
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checkOutput("cancel_busy", W'(busy), W'(0));
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("cancel_no_done", W'(doneSeen), W'(0));
        checkOutput("cancel_hi_kept", hi, lastHi);
        checkOutput("cancel_lo_kept", lo, lastLo);

        // Cancel and start together: start is dropped.
        start  = 1'b1;
        cancel = 1'b1;
        op     = 2'b01;
        src1   = 32'd5;
        src2   = 32'd5;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        checkOutput("cancel_start_busy", W'(busy), W'(0));
        @(negedge clk);

        applyStimulus(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, "after_cancel");
        waitDone(34, "after_cancel");
        @(negedge clk);

        // Back-to-back issue during DONE, with start pulses while busy.
        applyStimulus(2'b01, 32'd4, 32'd5, 32'd0, 32'd20, 1'b1, "b2b_first");
        waitDone(34, "b2b_first");
        applyStimulus(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1, "b2b_second");
        while (latCount < 5) begin
            @(negedge clk);
            latCount++;
        end
        start = 1'b1;
        op    = 2'b00;
        src1  = 32'd9;
        src2  = 32'd9;
        @(negedge clk);
        latCount++;
        start = 1'b0;
        waitDone(34, "b2b_second");
        @(negedge clk);
        checkOutput("b2b_lo_hold", lo, 32'd6);

        // Reset in cycle 20 of a DIV: everything clears at once.
        applyStimulus(2'b10, 32'd1000, 32'd3, '0, '0, 1'b0, "reset_div");
        while (latCount < 20) begin
            @(negedge clk);
            latCount++;
        end
        resetn = 1'b0;
        #1;
        checkOutput("midreset_busy", W'(busy), W'(0));
        checkOutput("midreset_done", W'(done), W'(0));
        checkOutput("midreset_hi", hi, W'(0));
        checkOutput("midreset_lo", lo, W'(0));
        @(negedge clk);
        resetn = 1'b1;
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        checkOutput("postreset_idle", W'(doneSeen), W'(0));

        applyStimulus(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, "postreset_divu");
        waitDone(34, "postreset_divu");
        repeat (2) @(negedge clk);

        checkOutput("scoreboard_empty", W'(scoreboard.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
